// File: rtl/board_store.sv
// Double-banked cellular-automaton board: the evolver writes the back bank while the
// display and evolver read the front bank; a generation-done pulse swaps the banks.
module board_store #(
    parameter int unsigned P_PARAM_M = 5,
    parameter int unsigned P_PARAM_N = 5,
    parameter int unsigned WIDTH     = 12
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        evo_active,
    input  logic [2*WIDTH-1:0]                          evo_rd_pos,
    output logic                                        evo_rd_data,
    input  logic                                        evo_wden,
    input  logic [2*WIDTH-1:0]                          evo_wr_pos,
    input  logic                                        evo_wr_data,
    input  logic                                        gen_done,
    input  logic [2*WIDTH-1:0]                          disp_pos,
    output logic                                        disp_data,
    input  logic                                        edit_en,
    input  logic [2*WIDTH-1:0]                          edit_pos,
    input  logic                                        clear,
    output logic [$clog2(P_PARAM_M*P_PARAM_N+1)-1:0]    pop_count,
    output logic [15:0]                                 gen_count
);

    localparam int unsigned CELLS = P_PARAM_M * P_PARAM_N;
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned IW    = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int unsigned CW    = $clog2(CELLS + 1);
    localparam logic [PW-1:0] LIMIT = PW'(CELLS);

    logic [CELLS-1:0] bank [2];
    logic             front;
    logic [CW-1:0]    tally;

    logic          rd_ok, disp_ok, wr_ok, wr_live, ed_ok, swap;
    logic [IW-1:0] rd_idx, disp_idx, wr_idx, ed_idx;

    // Range qualification and strobe decode
    always_comb begin
        rd_ok    = evo_rd_pos < LIMIT;
        disp_ok  = disp_pos < LIMIT;
        wr_ok    = evo_wden && (evo_wr_pos < LIMIT);
        wr_live  = wr_ok && evo_wr_data;
        ed_ok    = edit_en && !evo_active && (edit_pos < LIMIT);
        swap     = gen_done && evo_active;
        rd_idx   = evo_rd_pos[IW-1:0];
        disp_idx = disp_pos[IW-1:0];
        wr_idx   = evo_wr_pos[IW-1:0];
        ed_idx   = edit_pos[IW-1:0];
    end

    // Clear shares the reset path; it wipes everything including read registers
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            bank[0]     <= '0;
            bank[1]     <= '0;
            front       <= 1'b0;
            tally       <= '0;
            pop_count   <= '0;
            gen_count   <= '0;
            evo_rd_data <= 1'b0;
            disp_data   <= 1'b0;
        end else begin
            evo_rd_data <= rd_ok && bank[front][rd_idx];
            disp_data   <= disp_ok && bank[front][disp_idx];

            if (wr_ok) begin
                bank[~front][wr_idx] <= evo_wr_data;
            end

            if (ed_ok) begin
                bank[front][ed_idx] <= ~bank[front][ed_idx];
            end

            // A write in the swap cycle is counted into the new front population
            if (swap) begin
                front     <= ~front;
                pop_count <= tally + CW'(wr_live);
                tally     <= '0;
                gen_count <= gen_count + 16'd1;
            end else begin
                tally <= tally + CW'(wr_live);
                if (ed_ok) begin
                    if (bank[front][ed_idx]) begin
                        pop_count <= pop_count - CW'(1);
                    end else begin
                        pop_count <= pop_count + CW'(1);
                    end
                end
            end
        end
    end

endmodule
